valu_req_issuer: RTL and testbench
==================================

# valu_req_issuer

Command-to-beat sequencer that feeds the vector ALU pipelines (add/min/max/compare/average) from the front end. It accepts one vector instruction at a time (vl, SEW, base register address, op controls). It emits one request beat per DATA_WIDTH-wide register chunk, each carrying address, byte enables, element start index and first/last-beat flags, and holds every beat under downstream valid/ready backpressure.

## Interface
- DATA_WIDTH, 64: ALU datapath width in bits.
- BYTE_EN_WIDTH, DATA_WIDTH/8: byte-enable width.
- ADDR_WIDTH, 32: register-file beat address width.
- VL_WIDTH, 12: width of vector length field.
- OPSEL_WIDTH, 9: ALU op-select width, passed through.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high when state is IDLE; command accepted on cmd_valid & cmd_ready at a clk edge.
- cmd_vl  in  VL_WIDTH  element count.
- cmd_sew  in  2  element width, 0=8b, 1=16b, 2=32b, 3=64b.
- cmd_addr  in  ADDR_WIDTH  base beat address.
- cmd_opSel  in  OPSEL_WIDTH  ALU op select.
- cmd_avg  in  1  averaging (fixed-point) op flag.
- req_valid  out  1  beat valid.
- req_ready  in  1  downstream accepts beat.
- req_addr  out  ADDR_WIDTH  beat address.
- req_be  out  BYTE_EN_WIDTH  active bytes of beat.
- req_start_idx  out  3  low 3 bits of first element index of beat.
- req_start  out  1  first beat of command.
- req_end  out  1  last beat of command.
- req_sew  out  2  latched cmd_sew.
- req_opSel  out  OPSEL_WIDTH  latched cmd_opSel.
- req_avg  out  1  latched cmd_avg.
- busy  out  1  state is ISSUE.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - ISSUE: cmd_ready=0.
- IDLE, accepted command with cmd_vl!=0:
  - Latch sew, opSel, avg and base address.
  - Set remaining = cmd_vl and beat index b = 0.
  - Go to ISSUE.
- IDLE, accepted command with cmd_vl==0: consumed, no beats emitted, stay IDLE.
- Elements per beat: epb = BYTE_EN_WIDTH >> sew (8/4/2/1 at 64b).
- Per beat fields:
  - req_addr = base + b, modulo 2^ADDR_WIDTH.
  - req_start_idx = (b*epb)[2:0].
  - req_start = (b==0).
  - req_end = (remaining <= epb).
- req_be:
  - All ones when remaining >= epb.
  - Otherwise the low (remaining << sew) bits set, rest 0.
- On transfer (req_valid & req_ready):
  - b increments.
  - remaining decrements by epb.
  - If req_end, go to IDLE.
- While req_ready=0, every req_* field holds stable and req_valid stays 1.
- req_valid is 1 exactly when in ISSUE.
- Outside ISSUE, req_be, req_start, req_end and req_start_idx read 0. req_addr, req_sew, req_opSel and req_avg hold their last values.
- Total beats = ceil(vl/epb). Exactly one beat has req_start and exactly one has req_end; they are the same beat when vl <= epb.

## Timing
- Command accepted at edge T: first beat has req_valid=1 in the cycle after T. With req_ready tied high, throughput is one beat per cycle.
- Last beat transferred at edge E: IDLE with cmd_ready=1 in the cycle after E. The next command can be accepted at edge E+1, giving one bubble cycle between commands.
- Reset values:
  - req_valid, busy, req_start, req_end: 0.
  - req_be, req_addr, req_start_idx, req_sew, req_opSel, req_avg: 0.
  - Internal counters: 0. State: IDLE.
  - cmd_ready reads 1, but no command is accepted while rst=1.
- Reset mid-command: outputs go to reset values immediately (asynchronous). Remaining beats are dropped and not resumed.
- A cmd_valid pulse while in ISSUE is ignored; cmd_ready=0, and the upstream must hold it.
- Counter widths: remaining and b are VL_WIDTH bits. remaining never underflows, because the subtraction is only taken when remaining > epb.

## Test plan
- sew=1, vl=20, addr=0x40, ready=1 -> 5 beats on consecutive cycles, addr 0x40..0x44, be=0xFF each, start_idx 0,4,0,4,0, req_start on beat 0 only, req_end on beat 4 only.
- sew=2, vl=11 -> 6 beats, beats 0-4 be=0xFF, beat 5 be=0x0F with req_end=1. sew=0, vl=3 -> single beat, be=0x07, req_start=req_end=1.
- sew=3, vl=10, addr=0xFFFFFFFE -> 10 beats, start_idx 0..7,0,1, addr wraps 0xFFFFFFFE, 0xFFFFFFFF, 0x0, ..., be=0xFF all.
- Backpressure on the sew=1, vl=20, addr=0x40 command:
  - Stimulus: req_ready low for 3 cycles during beat 2, then high.
  - Response: beat 2 fields stable throughout, 5 total transfers, no duplicates or skips.
  - Then: cmd_valid asserted during ISSUE is not accepted until the cycle after the last transfer.
- vl=0 command -> accepted, no req_valid, cmd_ready stays 1. Back-to-back command follows on the next cycle.
- rst asserted on beat 3 of an 8-beat command -> req_valid=0 and be=0 asynchronously. After release, IDLE and cmd_ready=1; a new vl=8, sew=0 command issues one beat starting at its own base address.

Source files
------------

// File: rtl/valu_req_issuer.sv
// Vector ALU request issuer: turns one vector command into a stream of
// DATA_WIDTH-wide request beats, held stable under valid/ready backpressure.
module valu_req_issuer #(
  parameter int DATA_WIDTH    = 64,
  parameter int BYTE_EN_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int VL_WIDTH      = 12,
  parameter int OPSEL_WIDTH   = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [VL_WIDTH-1:0]      i_cmd_vl,
  input  logic [1:0]               i_cmd_sew,
  input  logic [ADDR_WIDTH-1:0]    i_cmd_addr,
  input  logic [OPSEL_WIDTH-1:0]   i_cmd_opsel,
  input  logic                     i_cmd_avg,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic [ADDR_WIDTH-1:0]    o_req_addr,
  output logic [BYTE_EN_WIDTH-1:0] o_req_be,
  output logic [2:0]               o_req_start_idx,
  output logic                     o_req_start,
  output logic                     o_req_end,
  output logic [1:0]               o_req_sew,
  output logic [OPSEL_WIDTH-1:0]   o_req_opsel,
  output logic                     o_req_avg,
  output logic                     o_busy
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  localparam logic [VL_WIDTH-1:0] BE_CNT = VL_WIDTH'(BYTE_EN_WIDTH);

  state_t                   r_state, w_state_nxt;
  logic [VL_WIDTH-1:0]      r_rem, r_b;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [1:0]               r_sew;
  logic [OPSEL_WIDTH-1:0]   r_opsel;
  logic                     r_avg;

  logic                     w_issue, w_accept, w_xfer, w_end;
  logic [VL_WIDTH-1:0]      w_epb, w_nbytes, w_prod;
  logic [BYTE_EN_WIDTH-1:0] w_be_part, w_be;

  assign w_issue  = (r_state == S_ISSUE);
  assign w_accept = i_cmd_valid & (r_state == S_IDLE);
  assign w_xfer   = w_issue & i_req_ready;
  assign w_epb    = BE_CNT >> r_sew;
  assign w_end    = (r_rem <= w_epb);
  assign w_nbytes = r_rem << r_sew;
  assign w_prod   = r_b * w_epb;

  // Partial beat: only the bytes of the remaining elements are enabled.
  always_comb begin
    w_be_part = '0;
    for (int i = 0; i < BYTE_EN_WIDTH; i++)
      w_be_part[i] = (VL_WIDTH'(i) < w_nbytes);
    w_be = (r_rem >= w_epb) ? '1 : w_be_part;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_cmd_ready = 1'b0;
    o_req_valid = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (w_accept && (i_cmd_vl != '0)) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        o_req_valid = 1'b1;
        o_busy      = 1'b1;
        if (w_xfer && w_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A zero-length command is consumed without touching the beat state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem   <= '0;
      r_b     <= '0;
      r_addr  <= '0;
      r_sew   <= '0;
      r_opsel <= '0;
      r_avg   <= 1'b0;
    end else if (w_accept && (i_cmd_vl != '0)) begin
      r_rem   <= i_cmd_vl;
      r_b     <= '0;
      r_addr  <= i_cmd_addr;
      r_sew   <= i_cmd_sew;
      r_opsel <= i_cmd_opsel;
      r_avg   <= i_cmd_avg;
    end else if (w_xfer && !w_end) begin
      r_rem  <= r_rem - w_epb;
      r_b    <= r_b + 1'b1;
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_req_addr      = r_addr;
  assign o_req_sew       = r_sew;
  assign o_req_opsel     = r_opsel;
  assign o_req_avg       = r_avg;
  assign o_req_be        = w_issue ? w_be : '0;
  assign o_req_start_idx = w_issue ? w_prod[2:0] : 3'd0;
  assign o_req_start     = w_issue & (r_b == '0);
  assign o_req_end       = w_issue & w_end;

endmodule

// File: tb/tb_valu_req_issuer.sv
// Scoreboard bench for valu_req_issuer: a reference model queues expected
// beats per command, the monitor pops and compares on every transfer.
module tb_valu_req_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [11:0] cmd_vl;
  logic [1:0]  cmd_sew;
  logic [31:0] cmd_addr;
  logic [8:0]  cmd_opsel;
  logic        cmd_avg;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_be;
  logic [2:0]  req_start_idx;
  logic        req_start, req_end;
  logic [1:0]  req_sew;
  logic [8:0]  req_opsel;
  logic        req_avg, busy;

  valu_req_issuer dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_vl(cmd_vl), .i_cmd_sew(cmd_sew), .i_cmd_addr(cmd_addr),
    .i_cmd_opsel(cmd_opsel), .i_cmd_avg(cmd_avg),
    .o_req_valid(req_valid), .i_req_ready(req_ready),
    .o_req_addr(req_addr), .o_req_be(req_be), .o_req_start_idx(req_start_idx),
    .o_req_start(req_start), .o_req_end(req_end), .o_req_sew(req_sew),
    .o_req_opsel(req_opsel), .o_req_avg(req_avg), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  be;
    logic [2:0]  idx;
    logic        st;
    logic        en;
    logic [1:0]  sew;
    logic [8:0]  opsel;
    logic        avg;
  } beat_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    n_beats = 0;
  int    end_cyc = -100;
  int    acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected beat list for one command.
  task automatic model_push(input int vl, input int sew, input logic [31:0] addr,
                            input logic [8:0] opsel, input logic avg);
    int    epb, rem, b;
    beat_t e;
    epb = 8 >> sew;
    rem = vl;
    b   = 0;
    while (rem > 0) begin
      e.addr  = addr + 32'(b);
      e.be    = (rem >= epb) ? 8'hFF : 8'((1 << (rem << sew)) - 1);
      e.idx   = 3'((b * epb) & 7);
      e.st    = (b == 0);
      e.en    = (rem <= epb);
      e.sew   = 2'(sew);
      e.opsel = opsel;
      e.avg   = avg;
      q.push_back(e);
      rem = e.en ? 0 : rem - epb;
      b++;
    end
  endtask

  // Monitor: compares each transferred beat and checks hold/idle behaviour.
  logic        hold_prev = 1'b0;
  logic [47:0] hold_val;
  always @(negedge clk) begin
    beat_t e;
    if (req_valid) begin
      if (hold_prev)
        chk("bp_stable", {req_addr, req_be, req_start_idx, req_start, req_end, req_sew, req_opsel[0]},
            hold_val);
      if (req_ready) begin
        n_beats++;
        if (req_end) end_cyc = cyc;
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("addr", req_addr, e.addr);
          chk("be", req_be, e.be);
          chk("start_idx", req_start_idx, e.idx);
          chk("start_end", {req_start, req_end}, {e.st, e.en});
          chk("sew_op_avg", {req_sew, req_opsel, req_avg}, {e.sew, e.opsel, e.avg});
        end
      end
      hold_prev = !req_ready;
      hold_val  = {req_addr, req_be, req_start_idx, req_start, req_end, req_sew, req_opsel[0]};
    end else begin
      hold_prev = 1'b0;
      chk("idle_fields", {busy, req_be, req_start_idx, req_start, req_end}, 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_cmd(input int vl, input int sew, input logic [31:0] addr,
                          input logic [8:0] opsel, input logic avg, output int waited);
    cmd_valid = 1'b1;
    cmd_vl    = 12'(vl);
    cmd_sew   = 2'(sew);
    cmd_addr  = addr;
    cmd_opsel = opsel;
    cmd_avg   = avg;
    waited    = 0;
    while (!cmd_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    else begin
      model_push(vl, sew, addr, opsel, avg);
      acc_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", (q.size() != 0 || busy), 0);
  endtask

  initial begin
    int w, base;
    rst = 1'b1; cmd_valid = 1'b1; cmd_vl = 12'd5; cmd_sew = 2'd0;
    cmd_addr = 32'h99; cmd_opsel = 9'h1FF; cmd_avg = 1'b1; req_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {cmd_ready, req_valid, busy, req_start, req_end}, 5'b10000);
    chk("rst_data", {req_addr, req_be, req_start_idx, req_sew, req_opsel, req_avg}, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sequences with ready tied high.
    send_cmd(20, 1, 32'h40, 9'h1A5, 1'b1, w);
    repeat (4) @(posedge clk);
    #1;
    chk("tput_last_beat", {req_valid, req_end}, 2'b11);
    drain();
    send_cmd(11, 2, 32'h100, 9'h033, 1'b0, w);
    drain();
    send_cmd(3, 0, 32'h200, 9'h0F0, 1'b1, w);
    drain();
    send_cmd(10, 3, 32'hFFFF_FFFE, 9'h10A, 1'b0, w);
    drain();
    chk("addr_hold_idle", req_addr, 32'h0000_0007);

    // Backpressure on beat 2, then a command held while busy.
    base = n_beats;
    send_cmd(20, 1, 32'h40, 9'h055, 1'b0, w);
    w = 0;
    while (n_beats - base != 2 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_reach_beat2", n_beats - base, 2);
    req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_ready = 1'b1;
    send_cmd(3, 0, 32'h300, 9'h001, 1'b1, w);
    chk("held_cmd_accept_cycle", acc_cyc, end_cyc + 2);
    chk("bp_total_beats", n_beats - base, 5);
    drain();

    // Zero-length command then back-to-back command.
    send_cmd(0, 1, 32'h400, 9'h002, 1'b0, w);
    chk("vl0_after", {cmd_ready, req_valid}, 2'b10);
    send_cmd(5, 1, 32'h500, 9'h003, 1'b0, w);
    chk("b2b_wait", w, 0);
    drain();

    // Reset on beat 3 of an 8-beat command.
    base = n_beats;
    send_cmd(64, 0, 32'h600, 9'h0AA, 1'b1, w);
    w = 0;
    while (n_beats - base != 3 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst_reach_beat3", n_beats - base, 3);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {req_valid, busy, req_be}, 0);
    chk("rst_async_addr", req_addr, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_release", {cmd_ready, req_valid}, 2'b10);
    base = n_beats;
    send_cmd(8, 0, 32'h700, 9'h0BB, 1'b0, w);
    drain();
    chk("post_rst_beats", n_beats - base, 1);

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
